// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first payload, optional parity and 1..2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_odd port and the PARITY state.
module uart_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 start_trans,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx_out,
  output logic                 tx_state,
  output logic                 tx_ready,
  output logic                 byte_send
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    SEND_BIT  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic [15:0]            baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_out_q, tx_out_d;
  logic                   tx_state_q, tx_state_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   byte_send_q, byte_send_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    byte_send_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_trans) begin
          state_d = START_BIT;
          baud_d  = '0;
          bit_d   = '0;
          shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ parity_odd;
`endif
        end
      end
      START_BIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = SEND_BIT;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      SEND_BIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      STOP: begin
        // bit counter is reused to count stop bits
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d       = '0;
            state_d     = IDLE;
            byte_send_d = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line matches the state it enters.
  always_comb begin
    tx_out_d   = 1'b1;
    tx_ready_d = (state_d == IDLE);
    tx_state_d = (state_d != IDLE);
    case (state_d)
      START_BIT: tx_out_d = 1'b0;
      SEND_BIT:  tx_out_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:    tx_out_d = par_d;
`endif
      default:   tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      tx_out_q    <= 1'b1;
      tx_state_q  <= 1'b0;
      tx_ready_q  <= 1'b1;
      byte_send_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      tx_out_q    <= tx_out_d;
      tx_state_q  <= tx_state_d;
      tx_ready_q  <= tx_ready_d;
      byte_send_q <= byte_send_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx_out    = tx_out_q;
  assign tx_state  = tx_state_q;
  assign tx_ready  = tx_ready_q;
  assign byte_send = byte_send_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: 8N1 and 5-bit/2-stop instances at 4 clocks per bit.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk;
  logic       Rst;
  logic       start1, start2;
  logic [7:0] data1;
  logic [4:0] data2;
  logic       podd1, podd2;
  logic       out1, st1, rdy1, bs1;
  logic       out2, st2, rdy2, bs2;

  int n_cmp;
  int n_err;

  uart_tx_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk         (clk),
    .Rst         (Rst),
    .start_trans (start1),
    .tx_data     (data1),
`ifdef UART_TX_PARITY_EN
    .parity_odd  (podd1),
`endif
    .tx_out      (out1),
    .tx_state    (st1),
    .tx_ready    (rdy1),
    .byte_send   (bs1)
  );

  uart_tx_ctrl #(.DATA_BITS(5), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk         (clk),
    .Rst         (Rst),
    .start_trans (start2),
    .tx_data     (data2),
`ifdef UART_TX_PARITY_EN
    .parity_odd  (podd2),
`endif
    .tx_out      (out2),
    .tx_state    (st2),
    .tx_ready    (rdy2),
    .byte_send   (bs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one frame from a negedge with the DUT idle; returns at the negedge of the byte_send cycle.
  task automatic frame(input logic [8:0] data, input logic odd, input bit hold,
                       input bit disturb, input bit which);
    logic exp_bits[16];
    int   nb, sb, n, c;
    logic par;
    nb = which ? 5 : 8;
    sb = which ? 2 : 1;
    n  = 0;
    exp_bits[n++] = 1'b0;
    par = odd;
    for (int d = 0; d < nb; d++) begin
      exp_bits[n++] = data[d];
      par = par ^ data[d];
    end
    if (PEN) exp_bits[n++] = par;
    for (int s = 0; s < sb; s++) exp_bits[n++] = 1'b1;

    if (which) begin data2 = data[4:0]; podd2 = odd; start2 = 1'b1; end
    else       begin data1 = data[7:0]; podd1 = odd; start1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin start1 = 1'b0; start2 = 1'b0; end

    c = 1;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 4; k++) begin
        check_eq($sformatf("tx_out d%0d data=%0h bit%0d c%0d", which, data, b, c),
                 {31'd0, which ? out2 : out1}, {31'd0, exp_bits[b]});
        check_eq($sformatf("tx_state d%0d c%0d", which, c), {31'd0, which ? st2 : st1}, 32'd1);
        if (k == 0)
          check_eq($sformatf("byte_send_low d%0d c%0d", which, c), {31'd0, which ? bs2 : bs1}, 32'd0);
        if (disturb && c == 10) begin
          data1 = ~data[7:0];
          start1 = 1'b1;
        end
        if (disturb && c == 20) start1 = 1'b0;
        c++;
        @(negedge clk);
      end
    end
    check_eq($sformatf("byte_send_pulse d%0d data=%0h c%0d", which, data, c), {31'd0, which ? bs2 : bs1}, 32'd1);
    check_eq($sformatf("tx_ready_end d%0d", which), {31'd0, which ? rdy2 : rdy1}, 32'd1);
    check_eq($sformatf("tx_state_end d%0d", which), {31'd0, which ? st2 : st1}, 32'd0);
    check_eq($sformatf("tx_out_idle d%0d", which), {31'd0, which ? out2 : out1}, 32'd1);
    $display("frame d%0d data=%0h odd=%0b hold=%0b disturb=%0b bits=%0d done", which, data, odd, hold, disturb, n);
  endtask

  initial begin
    int pulses;
    n_cmp = 0; n_err = 0;
    Rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    data1 = '0; data2 = '0; podd1 = 1'b0; podd2 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst tx_out", {31'd0, out1}, 32'd1);
    check_eq("rst tx_state", {31'd0, st1}, 32'd0);
    check_eq("rst tx_ready", {31'd0, rdy1}, 32'd1);
    check_eq("rst byte_send", {31'd0, bs1}, 32'd0);
    Rst = 1'b0;

    // 0xA5 immediately after reset release: line 0,1,0,1,0,0,1,0,1,1
    frame(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("byte_send_one_cycle", {31'd0, bs1}, 32'd0);
    check_eq("idle_tx_ready", {31'd0, rdy1}, 32'd1);

    if (PEN) begin
      frame(9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // back-to-back: start held through the byte_send cycle
    frame(9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("b2b_done_byte_send", {31'd0, bs1}, 32'd0);

    // start and new data while busy must not disturb the frame
    frame(9'h096, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("disturb_no_restart", {31'd0, st1}, 32'd0);

    // reset during data bit 3 of 0x3C (cycles 17..20)
    data1 = 8'h3C; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (17) @(negedge clk);
    check_eq("pre_rst tx_state", {31'd0, st1}, 32'd1);
    Rst = 1'b1;
    #1;
    check_eq("midrst tx_out", {31'd0, out1}, 32'd1);
    check_eq("midrst tx_state", {31'd0, st1}, 32'd0);
    check_eq("midrst tx_ready", {31'd0, rdy1}, 32'd1);
    check_eq("midrst byte_send", {31'd0, bs1}, 32'd0);
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (bs1 || st1) pulses++;
      @(negedge clk);
    end
    check_eq("post_rst quiet", pulses, 32'd0);
    frame(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 5 data bits, 2 stop bits: 32 cycles without parity
    frame(9'h01F, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("d2 byte_send_one_cycle", {31'd0, bs2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_BITS, 8: payload width per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter STOP_BITS, 1: number of stop bits; legal values 1 or 2.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port Rst, input, 1: asynchronous active-high reset.
REQ-007 Port start_trans, input, 1: request to transmit tx_data; sampled only in IDLE.
REQ-008 Port tx_data, input, DATA_BITS: payload; latched on the accepting edge.
REQ-009 Port parity_odd, input, 1: 1 selects odd parity, 0 selects even parity; present only with UART_TX_PARITY_EN.
REQ-010 Port tx_out, output, 1: serial line; idles high.
REQ-011 Port tx_state, output, 1: 0 means IDLE, 1 means BUSY.
REQ-012 Port tx_ready, output, 1: high exactly when in IDLE.
REQ-013 Port byte_send, output, 1: one-cycle pulse on frame completion.

Function
REQ-014 States SHALL be IDLE, START_BIT, SEND_BIT, PARITY, STOP; all outputs SHALL be registered.
REQ-015 IDLE->START_BIT SHALL occur on the rising edge where start_trans=1; tx_data and parity_odd SHALL be latched on that same edge.
REQ-016 tx_out SHALL go low in the cycle after acceptance and SHALL hold each bit for exactly CLKS_PER_BIT cycles.
REQ-017 SEND_BIT SHALL shift the payload out LSB first, using a bit counter running 0..DATA_BITS-1.
REQ-018 After the last data bit, the FSM SHALL enter PARITY if parity is compiled in; otherwise it SHALL enter STOP.
REQ-019 STOP SHALL drive tx_out high for STOP_BITS*CLKS_PER_BIT cycles and then return to IDLE.
REQ-020 Frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
REQ-021 byte_send SHALL be high only during the first IDLE cycle after STOP.
REQ-022 start_trans asserted in that same cycle SHALL be accepted, giving back-to-back frames with no extra idle gap.
REQ-023 start_trans SHALL be ignored while tx_state=1; a changing tx_data while BUSY SHALL not affect the frame in flight.
REQ-024 The baud counter SHALL restart at 0 on every state or bit change; it SHALL never wrap mid-bit.
REQ-025 An illegal state encoding SHALL return the FSM to IDLE on the next edge with tx_out=1.

Reset
REQ-026 While Rst=1, regardless of clk: state=IDLE, tx_out=1, tx_state=0, tx_ready=1, byte_send=0, counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; no byte_send pulse SHALL follow.
REQ-028 The first start_trans SHALL be accepted on the first rising edge after Rst deasserts.

Configuration
REQ-029 The macro UART_TX_PARITY_EN SHALL control the parity feature.
REQ-030 With UART_TX_PARITY_EN defined: port parity_odd SHALL exist, the PARITY state SHALL exist, and the parity bit SHALL equal XOR(payload) XOR parity_odd, sent for CLKS_PER_BIT cycles.
REQ-031 With UART_TX_PARITY_EN undefined: parity_odd and the PARITY state SHALL be absent, and frames SHALL carry no parity bit.

Verification (DATA_BITS=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-032 No parity: start_trans with tx_data=0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; byte_send pulses at cycle 41 after acceptance.
REQ-033 Parity on, 0xA5: parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; frame is 44 cycles.
REQ-034 start_trans held high continuously with 0x00 then 0xFF -> two frames separated by zero idle cycles; two byte_send pulses.
REQ-035 Rst pulsed during data bit 3 -> tx_out=1, tx_state=0 immediately; no byte_send; the next 0x3C frame is correct.
REQ-036 start_trans and a changed tx_data while BUSY -> ignored; the original byte is transmitted intact.
REQ-037 STOP_BITS=2, DATA_BITS=5, tx_data=0x1F -> 8-bit frame (32 cycles, no parity) with a stop period 8 cycles long.
